// File: rtl/mul_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_if
//  Purpose  : Request/response bundle between the execute stage and the
//             iterative multiply/divide unit.
//  Signals  : start  - request, sampled only while busy is low
//             funct3 - operation select (RV32M encoding)
//             src_a  - rs1 operand (multiplicand / dividend)
//             src_b  - rs2 operand (multiplier / divisor)
//             flush  - abort the in-flight operation
//             busy   - operation in progress (pipeline stall)
//             done   - one-cycle pulse, result valid
//             result - result word, held until the next done
//  Revision : 1.0 - initial release
// ============================================================================
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative RV32M multiply/divide unit. Signed operands are turned
//             into magnitudes on acceptance, an unsigned shift-add multiplier
//             or restoring divider runs ITERS steps, and the sign is restored
//             when the result is written. Divide-by-zero and signed overflow
//             are resolved at acceptance and bypass the iteration.
//  Ports    : clk_i  - rising-edge clock
//             rst_ni - asynchronous active-low reset
//             bus    - mul_div_if.slave (start/funct3/src_a/src_b/flush in,
//                      busy/done/result out)
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  wire logic   clk_i,
  input  wire logic   rst_ni,
  mul_div_if.slave    bus
);

  localparam int CNT_W = $clog2(ITERS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               special_q, special_d;
  logic [WIDTH-1:0]   spec_res_q, spec_res_d;
  // Multiply: {partial high word, remaining multiplier bits}.
  // Divide  : {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  // FSM control outputs
  logic w_accept;
  logic w_iterate;
  logic w_abort;
  logic w_finish;

  // --------------------------------------------------------------------------
  // Acceptance decode (from the live request)
  // --------------------------------------------------------------------------
  logic             w_in_div;
  logic             w_a_signed, w_b_signed;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_div_zero, w_div_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic             w_neg;

  always_comb begin
    w_in_div   = bus.funct3[2];
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 so.
    w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3[2] && !bus.funct3[0]);
    w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3[2] && !bus.funct3[0]);
    w_sa       = w_a_signed && bus.src_a[WIDTH-1];
    w_sb       = w_b_signed && bus.src_b[WIDTH-1];
    w_mag_a    = w_sa ? (~bus.src_a + 1'b1) : bus.src_a;
    w_mag_b    = w_sb ? (~bus.src_b + 1'b1) : bus.src_b;

    w_div_zero = w_in_div && (bus.src_b == '0);
    w_div_ovf  = w_in_div && !bus.funct3[0] &&
                 (bus.src_a == SMIN) && (bus.src_b == ALL_ONES);
    w_special  = w_div_zero || w_div_ovf;

    // funct3[1] distinguishes remainder from quotient.
    if (w_div_zero) begin
      w_spec_res = bus.funct3[1] ? bus.src_a : ALL_ONES;
    end else begin
      w_spec_res = bus.funct3[1] ? '0 : SMIN;
    end

    if (w_in_div) begin
      w_neg = bus.funct3[1] ? w_sa : (w_sa ^ w_sb);
    end else begin
      // MUL low word is sign-agnostic, so it never needs negation.
      w_neg = (bus.funct3 == 3'b000) ? 1'b0 : (w_sa ^ w_sb);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = w_special ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_accept  = (state_q == S_IDLE) && bus.start && !bus.flush;
    w_iterate = (state_q == S_RUN) && !bus.flush;
    w_abort   = (state_q == S_RUN) && bus.flush;
    w_finish  = (state_q == S_FIN);
    bus.busy  = (state_q != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath: one iteration step and result formation
  // --------------------------------------------------------------------------
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_mul_res, w_div_res, w_final;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the whole {carry, high, low} window right by one.
    w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

    // Restoring divide: bring in the next dividend bit and trial-subtract.
    // A clear borrow bit means the shifted remainder covers the divisor.
    w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, opb_q};
    w_div_ge    = !w_div_diff[WIDTH];
    w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];

    w_prod_s    = neg_q ? (~acc_q + 1'b1) : acc_q;
    w_mul_res   = (op_q[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0]
                                       : w_prod_s[2*WIDTH-1:WIDTH];

    w_quo       = acc_q[WIDTH-1:0];
    w_rem       = acc_q[2*WIDTH-1:WIDTH];
    if (op_q[1]) begin
      w_div_res = neg_q ? (~w_rem + 1'b1) : w_rem;
    end else begin
      w_div_res = neg_q ? (~w_quo + 1'b1) : w_quo;
    end

    if (special_q) begin
      w_final = spec_res_q;
    end else begin
      w_final = op_q[2] ? w_div_res : w_mul_res;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_d      = neg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    result_d   = result_q;
    done_d     = 1'b0;

    if (w_accept) begin
      cnt_d      = '0;
      op_d       = bus.funct3;
      neg_d      = w_neg;
      special_d  = w_special;
      spec_res_d = w_spec_res;
      if (w_in_div) begin
        acc_d = {{WIDTH{1'b0}}, w_mag_a};
        opb_d = w_mag_b;
      end else begin
        acc_d = {{WIDTH{1'b0}}, w_mag_b};
        opb_d = w_mag_a;
      end
    end else if (w_iterate) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q[2]) begin
        acc_d = {w_div_rem, acc_q[WIDTH-2:0], w_div_ge};
      end else begin
        acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
      end
    end else if (w_abort) begin
      cnt_d = '0;
    end

    if (w_finish) begin
      result_d = w_final;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Directed self-checking bench for mul_div_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.src_a  = a;
    bus.src_b  = b;
    tick();
    bus.start  = 1'b0;
  endtask

  // Called just after the acceptance edge; DONE must rise exactly lat edges on.
  task automatic wait_done(input string tag, input int lat, input logic [31:0] exp);
    logic early;
    early = 1'b0;
    for (int i = 1; i < lat; i++) begin
      tick();
      if (bus.done) early = 1'b1;
    end
    check({tag, " early done"}, {31'b0, early}, 32'd0);
    tick();
    check({tag, " done"}, {31'b0, bus.done}, 32'd1);
    check({tag, " result"}, bus.result, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp);
    issue(f, a, b);
    check({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
    wait_done(tag, lat, exp);
    tick();
    check({tag, " pulse end"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    logic seen;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.flush  = 1'b0;

    #12;
    check("reset busy",   {31'b0, bus.busy}, 32'd0);
    check("reset done",   {31'b0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Multiplies
    run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB);
    run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 33, 32'h40000000);
    run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
    run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF);

    // Divides
    run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
    run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
    run_op("DIVU",   3'b101, 32'd100,      32'd7, 33, 32'd14);
    run_op("REMU",   3'b111, 32'd100,      32'd7, 33, 32'd2);

    // Special cases
    run_op("DIVU by 0", 3'b101, 32'd5,        32'd0,        1, 32'hFFFFFFFF);
    run_op("REM by 0",  3'b110, 32'd5,        32'd0,        1, 32'd5);
    run_op("DIV ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    run_op("REM ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);

    // START while busy is ignored; then back-to-back issue in the DONE cycle
    issue(3'b000, 32'd3, 32'd5);
    repeat (4) tick();
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.src_a  = 32'd100;
    bus.src_b  = 32'd100;
    tick();
    bus.start  = 1'b0;
    wait_done("ignored start", 28, 32'd15);
    issue(3'b101, 32'd100, 32'd7);
    check("b2b busy", {31'b0, bus.busy}, 32'd1);
    check("b2b pulse end", {31'b0, bus.done}, 32'd0);
    wait_done("b2b DIVU", 33, 32'd14);
    tick();

    // Flush mid-divide: no DONE, result unchanged
    issue(3'b100, 32'd1000, 32'd3);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy", {31'b0, bus.busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check("flush no done", {31'b0, seen}, 32'd0);
    check("flush result", bus.result, 32'd14);

    // Asynchronous reset mid-multiply
    issue(3'b000, 32'd7, 32'd9);
    repeat (3) tick();
    check("pre-reset busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async busy",   {31'b0, bus.busy}, 32'd0);
    check("async done",   {31'b0, bus.done}, 32'd0);
    check("async result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("post-reset MULHU", 3'b011, 32'h00010000, 32'h00010000, 33, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
